// File: rtl/regfile_commit_writer.sv
// regfile_commit_writer
//   In-order commit buffer feeding the single architectural register-file
//   write port. Dispatch allocates entries in program order, execute units
//   complete them out of order by tag, and the head entry retires in order
//   (at most one per cycle) once complete, producing a registered write.
//
// Optional feature macro: COMMIT_BYPASS_EN
//   When defined, a completion that targets the valid head entry retires it on
//   the same edge using Done_Data (1-cycle done-to-write latency instead of 2).
//
// Ports
//   CLK, RESET                clock, asynchronous active-high reset
//   Alloc_Valid/HasDest/Reg   dispatch allocation request and destination
//   Alloc_Ready, Alloc_Tag    entry available (Count != DEPTH), tag = tail
//   Done_Valid/Tag/Data       completion strobe, tag and result
//   Flush                     synchronous squash of all entries
//   Write1/WriteReg1/WriteData1  registered register-file write port
//   Count, Empty              occupancy, Count == 0
module regfile_commit_writer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Alloc_Valid,
  input  logic             Alloc_HasDest,
  input  logic [4:0]       Alloc_Reg,
  output logic             Alloc_Ready,
  output logic [TAG_W-1:0] Alloc_Tag,
  input  logic             Done_Valid,
  input  logic [TAG_W-1:0] Done_Tag,
  input  logic [31:0]      Done_Data,
  input  logic             Flush,
  output logic             Write1,
  output logic [4:0]       WriteReg1,
  output logic [31:0]      WriteData1,
  output logic [TAG_W:0]   Count,
  output logic             Empty
);

  localparam logic [TAG_W:0] LP_FULL = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_ready;
  logic [DEPTH-1:0] r_hasdest;
  logic [4:0]       r_reg  [DEPTH];
  logic [31:0]      r_data [DEPTH];

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic             r_write;
  logic [4:0]       r_write_reg;
  logic [31:0]      r_write_data;

  logic             w_not_full;
  logic             w_alloc;
  logic             w_done_hit;
  logic             w_retire;
  logic [31:0]      w_ret_data;
  logic             w_ret_write;
  logic [TAG_W:0]   w_count_d;

  assign w_not_full = (r_count != LP_FULL);
  // Full buffer refuses allocation even if the head retires this cycle.
  assign w_alloc    = Alloc_Valid & w_not_full;
  assign w_done_hit = Done_Valid & r_valid[Done_Tag];

`ifdef COMMIT_BYPASS_EN
  logic w_bypass;
  assign w_bypass   = Done_Valid & (Done_Tag == r_head) & r_valid[r_head];
  assign w_retire   = ~Flush & r_valid[r_head] & (r_ready[r_head] | w_bypass);
  assign w_ret_data = w_bypass ? Done_Data : r_data[r_head];
`else
  assign w_retire   = ~Flush & r_valid[r_head] & r_ready[r_head];
  assign w_ret_data = r_data[r_head];
`endif

  // r0 and no-destination entries retire without a visible write.
  assign w_ret_write = w_retire & r_hasdest[r_head] & (r_reg[r_head] != 5'd0);

  always_comb begin
    w_count_d = r_count;
    unique case ({w_alloc, w_retire})
      2'b10:   w_count_d = r_count + (TAG_W+1)'(1);
      2'b01:   w_count_d = r_count - (TAG_W+1)'(1);
      default: w_count_d = r_count;
    endcase
  end

  // Control state: valid/ready bits, pointers, count and the write port.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid      <= '0;
      r_ready      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_write      <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else if (Flush) begin
      r_valid <= '0;
      r_ready <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_write <= 1'b0;
    end else begin
      // An allocating entry is never valid, so a completion can never hit
      // the tail slot being written on the same edge.
      if (w_done_hit) begin
        r_ready[Done_Tag] <= 1'b1;
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + TAG_W'(1);
        r_write_reg     <= r_reg[r_head];
        r_write_data    <= w_ret_data;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_tail          <= r_tail + TAG_W'(1);
      end
      r_count <= w_count_d;
      r_write <= w_ret_write;
    end
  end

  // Payload storage needs no reset; it is only read behind a valid bit.
  always_ff @(posedge CLK) begin
    if (w_alloc && !Flush) begin
      r_hasdest[r_tail] <= Alloc_HasDest;
      r_reg[r_tail]     <= Alloc_Reg;
    end
    if (w_done_hit && !Flush) begin
      r_data[Done_Tag] <= Done_Data;
    end
  end

  assign Alloc_Ready = w_not_full;
  assign Alloc_Tag   = r_tail;
  assign Write1      = r_write;
  assign WriteReg1   = r_write_reg;
  assign WriteData1  = r_write_data;
  assign Count       = r_count;
  assign Empty       = (r_count == '0);

endmodule

// File: tb/tb_regfile_commit_writer.sv
// Directed bench for regfile_commit_writer (DEPTH=8). Inputs change 1 time
// unit after a rising edge; outputs are sampled at that same point.
module tb_regfile_commit_writer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = 3;
`ifdef COMMIT_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic             CLK;
  logic             RESET;
  logic             Alloc_Valid;
  logic             Alloc_HasDest;
  logic [4:0]       Alloc_Reg;
  logic             Alloc_Ready;
  logic [TAG_W-1:0] Alloc_Tag;
  logic             Done_Valid;
  logic [TAG_W-1:0] Done_Tag;
  logic [31:0]      Done_Data;
  logic             Flush;
  logic             Write1;
  logic [4:0]       WriteReg1;
  logic [31:0]      WriteData1;
  logic [TAG_W:0]   Count;
  logic             Empty;

  int n_cmp = 0;
  int n_err = 0;

  regfile_commit_writer #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .Alloc_Valid   (Alloc_Valid),
    .Alloc_HasDest (Alloc_HasDest),
    .Alloc_Reg     (Alloc_Reg),
    .Alloc_Ready   (Alloc_Ready),
    .Alloc_Tag     (Alloc_Tag),
    .Done_Valid    (Done_Valid),
    .Done_Tag      (Done_Tag),
    .Done_Data     (Done_Data),
    .Flush         (Flush),
    .Write1        (Write1),
    .WriteReg1     (WriteReg1),
    .WriteData1    (WriteData1),
    .Count         (Count),
    .Empty         (Empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_flush();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
  endtask

  task automatic alloc(input logic hasdest, input logic [4:0] rg);
    Alloc_Valid   = 1'b1;
    Alloc_HasDest = hasdest;
    Alloc_Reg     = rg;
    step();
    Alloc_Valid   = 1'b0;
  endtask

  task automatic done(input logic [TAG_W-1:0] tag, input logic [31:0] data);
    Done_Valid = 1'b1;
    Done_Tag   = tag;
    Done_Data  = data;
    step();
    Done_Valid = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; Alloc_Valid = 1'b0; Alloc_HasDest = 1'b0; Alloc_Reg = '0;
    Done_Valid = 1'b0; Done_Tag = '0; Done_Data = '0; Flush = 1'b0;

    // Reset state
    #3;
    check_eq("rst_write1", 32'(Write1), 32'd0);
    check_eq("rst_wreg", 32'(WriteReg1), 32'd0);
    check_eq("rst_wdata", WriteData1, 32'd0);
    check_eq("rst_count", 32'(Count), 32'd0);
    check_eq("rst_empty", 32'(Empty), 32'd1);
    check_eq("rst_ready", 32'(Alloc_Ready), 32'd1);
    check_eq("rst_tag", 32'(Alloc_Tag), 32'd0);
    #9 RESET = 1'b0;
    step();

    // Single alloc/complete/write
    check_eq("t1_tag", 32'(Alloc_Tag), 32'd0);
    alloc(1'b1, 5'd5);
    check_eq("t1_count1", 32'(Count), 32'd1);
    check_eq("t1_empty0", 32'(Empty), 32'd0);
    done(3'd0, 32'hDEAD_BEEF);
    if (LAT == 2) begin
      check_eq("t1_nowrite_e0", 32'(Write1), 32'd0);
      step();
    end
    check_eq("t1_write1", 32'(Write1), 32'd1);
    check_eq("t1_wreg", 32'(WriteReg1), 32'd5);
    check_eq("t1_wdata", WriteData1, 32'hDEAD_BEEF);
    check_eq("t1_count0", 32'(Count), 32'd0);
    step();
    check_eq("t1_write1_off", 32'(Write1), 32'd0);
    check_eq("t1_wreg_hold", 32'(WriteReg1), 32'd5);
    check_eq("t1_wdata_hold", WriteData1, 32'hDEAD_BEEF);

    // Out-of-order completion, in-order retire
    do_flush();
    check_eq("t2_tag_after_flush", 32'(Alloc_Tag), 32'd0);
    alloc(1'b1, 5'd3);
    alloc(1'b1, 5'd4);
    alloc(1'b1, 5'd6);
    check_eq("t2_count3", 32'(Count), 32'd3);
    done(3'd2, 32'h22);
    check_eq("t2_nowrite_a", 32'(Write1), 32'd0);
    done(3'd1, 32'h11);
    check_eq("t2_nowrite_b", 32'(Write1), 32'd0);
    done(3'd0, 32'h00);
    if (LAT == 2) begin
      check_eq("t2_nowrite_c", 32'(Write1), 32'd0);
      step();
    end
    check_eq("t2_w0_en", 32'(Write1), 32'd1);
    check_eq("t2_w0_reg", 32'(WriteReg1), 32'd3);
    check_eq("t2_w0_data", WriteData1, 32'h00);
    step();
    check_eq("t2_w1_en", 32'(Write1), 32'd1);
    check_eq("t2_w1_reg", 32'(WriteReg1), 32'd4);
    check_eq("t2_w1_data", WriteData1, 32'h11);
    step();
    check_eq("t2_w2_en", 32'(Write1), 32'd1);
    check_eq("t2_w2_reg", 32'(WriteReg1), 32'd6);
    check_eq("t2_w2_data", WriteData1, 32'h22);
    step();
    check_eq("t2_end_write", 32'(Write1), 32'd0);
    check_eq("t2_end_count", 32'(Count), 32'd0);

    // Fill, overflow attempt, wrap
    do_flush();
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t3_tag%0d", i), 32'(Alloc_Tag), 32'(i));
      alloc(1'b1, 5'(i + 8));
    end
    check_eq("t3_count8", 32'(Count), 32'd8);
    check_eq("t3_ready0", 32'(Alloc_Ready), 32'd0);
    check_eq("t3_tag_full", 32'(Alloc_Tag), 32'd0);
    alloc(1'b1, 5'd31);
    check_eq("t3_count_ovf", 32'(Count), 32'd8);
    check_eq("t3_tag_ovf", 32'(Alloc_Tag), 32'd0);
    done(3'd0, 32'hA0);
    if (LAT == 2) begin
      check_eq("t3_count_e0", 32'(Count), 32'd8);
      step();
    end
    check_eq("t3_ret_write", 32'(Write1), 32'd1);
    check_eq("t3_ret_reg", 32'(WriteReg1), 32'd8);
    check_eq("t3_ret_data", WriteData1, 32'hA0);
    check_eq("t3_count7", 32'(Count), 32'd7);
    check_eq("t3_ready1", 32'(Alloc_Ready), 32'd1);
    check_eq("t3_wrap_tag", 32'(Alloc_Tag), 32'd0);
    alloc(1'b1, 5'd20);
    check_eq("t3_count_refill", 32'(Count), 32'd8);
    check_eq("t3_tag_after_wrap", 32'(Alloc_Tag), 32'd1);

    // Silent retires: r0 and no destination
    do_flush();
    alloc(1'b1, 5'd0);
    alloc(1'b0, 5'd7);
    done(3'd0, 32'h1234);
    check_eq("t4_silent_a", 32'(Write1), 32'd0);
    done(3'd1, 32'h5678);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t4_silent_%0d", i), 32'(Write1), 32'd0);
      step();
    end
    check_eq("t4_count0", 32'(Count), 32'd0);
    check_eq("t4_empty", 32'(Empty), 32'd1);

    // Flush beats the retire of the head
    do_flush();
    for (int i = 0; i < 4; i++) alloc(1'b1, 5'(i + 1));
    done(3'd1, 32'h77);
    Flush = (LAT == 1);
    done(3'd0, 32'h66);
    if (LAT == 2) begin
      Flush = 1'b1;
      step();
    end
    Flush = 1'b0;
    check_eq("t5_nowrite", 32'(Write1), 32'd0);
    check_eq("t5_count0", 32'(Count), 32'd0);
    check_eq("t5_empty", 32'(Empty), 32'd1);
    check_eq("t5_tag0", 32'(Alloc_Tag), 32'd0);
    done(3'd2, 32'h99);
    check_eq("t5_late_done_count", 32'(Count), 32'd0);
    step();
    check_eq("t5_late_done_write", 32'(Write1), 32'd0);

    // Asynchronous reset while a write is being presented
    alloc(1'b1, 5'd11);
    done(3'd0, 32'h5555_AAAA);
    if (LAT == 2) step();
    check_eq("t6_write_pre", 32'(Write1), 32'd1);
    check_eq("t6_wreg_pre", 32'(WriteReg1), 32'd11);
    #2 RESET = 1'b1;
    #1;
    check_eq("t6_write_async", 32'(Write1), 32'd0);
    check_eq("t6_wreg_async", 32'(WriteReg1), 32'd0);
    check_eq("t6_wdata_async", WriteData1, 32'd0);
    check_eq("t6_count_async", 32'(Count), 32'd0);
    #2 RESET = 1'b0;
    step();
    check_eq("t6_empty_after", 32'(Empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
